// File: rtl/p2s_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared P2S shifter.
// Optional transfer watchdog: define P2S_ARB_TIMEOUT_EN.
module p2s_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_BITS      = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_BITS        = 11
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       p2s_serial,
  output logic [DATA_BITS-1:0]       p2s_data,
  input  logic                       p2s_en,
  output logic                       busy,
  output logic                       err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 1 || N_REQ > 8) begin : g_bad_nreq
    $error("p2s_arbiter: N_REQ out of range");
  end
  if (TO_BITS < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_to_bits
    $error("p2s_arbiter: TO_BITS too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          r_owner;
  logic [PW-1:0]          w_sel;
  logic [PW-1:0]          w_cand;
  logic [PW-1:0]          w_ptr_next;
  logic                   w_any;
  logic                   w_grant;
  logic                   w_finish;
  logic                   w_abort;
  logic                   w_to_hit;
  logic [N_REQ-1:0]       r_gnt;
  logic [N_REQ-1:0]       r_done;
  logic                   r_serial;
  logic [DATA_BITS-1:0]   r_data;
  logic [1:0]             r_start_cnt;
  logic [DATA_BITS-1:0]   w_words [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign w_words[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  // Scan offsets high-to-low so the nearest requester at/after the pointer wins.
  always_comb begin
    int w_sum;
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    w_sum  = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_cand = PW'(w_sum);
      if (req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_ptr_next = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef P2S_ARB_TIMEOUT_EN
  logic [TO_BITS-1:0] r_to_cnt;
  logic               r_err;

  assign w_to_hit = (r_to_cnt == TO_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_state_next != r_state) begin
        r_to_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_to_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p2s_en && w_any) begin
          w_state_next = S_START;
          w_grant      = 1'b1;
        end
      end
      // Three cycles: one of grant-to-strobe latency, then two strobe-high cycles.
      S_START: begin
        if (r_start_cnt == 2'd2) w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!p2s_en) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_to_hit) begin
          w_state_next = S_IDLE;
          w_abort      = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (p2s_en) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end else if (w_to_hit) begin
          w_state_next = S_IDLE;
          w_abort      = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_serial    <= 1'b0;
      r_data      <= '0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_start_cnt <= '0;
    end else begin
      r_done   <= '0;
      r_serial <= (r_state == S_START) && (r_start_cnt != 2'd2);
      if (r_state == S_START) r_start_cnt <= r_start_cnt + 1'b1;
      if (w_grant) begin
        r_gnt       <= N_REQ'(1) << w_sel;
        r_owner     <= w_sel;
        r_data      <= w_words[w_sel];
        r_start_cnt <= '0;
      end
      if (w_finish) r_done <= r_gnt;
      if (w_finish || w_abort) begin
        r_gnt <= '0;
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign p2s_serial = r_serial;
  assign p2s_data   = r_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed bench for p2s_arbiter with a small behavioural P2S shifter model.
module tb_p2s_arbiter;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [127:0] req_data = '0;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         p2s_serial;
  logic [63:0]  p2s_data;
  logic         p2s_en;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  // P2S model: 2-FF edge detect on Serial, then EN low for 8 cycles.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_en = 1'b1;
  int   m_cnt = 0;
  logic f_on = 1'b0;
  logic f_val = 1'b1;

  assign p2s_en = f_on ? f_val : m_en;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_s1 <= p2s_serial;
    m_s2 <= m_s1;
    if (m_s1 && !m_s2) begin
      m_en  <= 1'b0;
      m_cnt <= 8;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_en <= 1'b1;
    end
  end

  p2s_arbiter #(
    .N_REQ(2),
    .DATA_BITS(64),
    .TIMEOUT_CYCLES(16),
    .TO_BITS(5)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .done(done),
    .p2s_serial(p2s_serial),
    .p2s_data(p2s_data),
    .p2s_en(p2s_en),
    .busy(busy),
    .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    req  = 2'b00;
    f_on = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == 2'b00 && n < 50) begin
      tick;
      n++;
    end
    check({tag, "_gnt_in_time"}, 64'(n < 50), 64'd1);
  endtask

  task automatic wait_done(input string tag, output logic [1:0] d);
    int n = 0;
    while (done == 2'b00 && n < 200) begin
      tick;
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < 200), 64'd1);
    d = done;
  endtask

  task automatic wait_en_low(input string tag);
    int n = 0;
    while (p2s_en && n < 50) begin
      tick;
      n++;
    end
    check({tag, "_en_low_in_time"}, 64'(n < 50), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] d;
    logic [1:0] exp_g;
    int         n_pulse;

    // Reset values, sampled while rstn is still asserted.
    rstn = 1'b0;
    tick;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_serial", 64'(p2s_serial), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", p2s_data, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    do_reset;

    // Single request: word appears with grant, strobe 1 cycle later for 2 cycles.
    req_data[63:0] = 64'hA5;
    req = 2'b01;
    tick;
    req = 2'b00;
    check("single_gnt", 64'(gnt), 64'h1);
    check("single_data", p2s_data, 64'hA5);
    check("single_serial_lat", 64'(p2s_serial), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    tick;
    check("single_serial_hi1", 64'(p2s_serial), 64'd1);
    tick;
    check("single_serial_hi2", 64'(p2s_serial), 64'd1);
    tick;
    check("single_serial_lo", 64'(p2s_serial), 64'd0);
    wait_done("single", d);
    check("single_done", 64'(d), 64'h1);
    tick;
    check("single_done_1cyc", 64'(done), 64'd0);
    check("single_gnt_clr", 64'(gnt), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // Round robin with both requests held; shifter busy externally blocks grants.
    do_reset;
    req  = 2'b11;
    f_on = 1'b1;
    f_val = 1'b0;
    repeat (5) tick;
    check("rr_no_gnt_en0", 64'(gnt), 64'd0);
    check("rr_idle_en0", 64'(busy), 64'd0);
    f_on = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_gnt("rr");
      check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(exp_g));
      wait_done("rr", d);
      check($sformatf("rr_done%0d", k), 64'(d), 64'(exp_g));
    end

    // Requester 1 drops its request in WAIT_BUSY: transfer still completes.
    do_reset;
    req = 2'b10;
    wait_gnt("drop");
    check("drop_gnt", 64'(gnt), 64'h2);
    repeat (3) tick;
    req = 2'b00;
    wait_done("drop", d);
    check("drop_done", 64'(d), 64'h2);
    tick;
    req = 2'b11;
    wait_gnt("drop_next");
    check("drop_ptr_wrap", 64'(gnt), 64'h1);
    req = 2'b00;
    wait_done("drop_next", d);

    // Data stability: source word changes mid-shift, p2s_data holds until next grant.
    do_reset;
    req_data[63:0] = 64'h11;
    req = 2'b01;
    wait_gnt("stab");
    req = 2'b00;
    wait_en_low("stab");
    req_data[63:0] = 64'h22;
    tick;
    check("stab_wait_done", p2s_data, 64'h11);
    wait_done("stab", d);
    check("stab_at_done", p2s_data, 64'h11);
    tick;
    check("stab_idle", p2s_data, 64'h11);
    req = 2'b01;
    wait_gnt("stab_next");
    check("stab_new_grant", p2s_data, 64'h22);
    req = 2'b00;
    wait_done("stab_next", d);

    // Reset in WAIT_DONE abandons the transfer without a done pulse.
    req_data[63:0] = 64'hA5;
    tick;
    req = 2'b01;
    wait_gnt("rstmid");
    req = 2'b00;
    wait_en_low("rstmid");
    tick;
    tick;
    rstn = 1'b0;
    #1;
    check("rstmid_gnt", 64'(gnt), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_serial", 64'(p2s_serial), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    tick;
    rstn = 1'b1;
    n_pulse = 0;
    repeat (30) begin
      tick;
      if (done != 2'b00) n_pulse++;
    end
    check("rstmid_no_done", 64'(n_pulse), 64'd0);

`ifdef P2S_ARB_TIMEOUT_EN
    // EN stuck high: abort after 16 cycles in WAIT_BUSY, sticky err.
    do_reset;
    f_on  = 1'b1;
    f_val = 1'b1;
    req = 2'b01;
    tick;
    req = 2'b00;
    check("to_gnt", 64'(gnt), 64'h1);
    n_pulse = 0;
    repeat (18) begin
      tick;
      if (done != 2'b00) n_pulse++;
    end
    check("to_busy_before", 64'(busy), 64'd1);
    check("to_err_before", 64'(err), 64'd0);
    tick;
    check("to_busy_after", 64'(busy), 64'd0);
    check("to_err_after", 64'(err), 64'd1);
    check("to_gnt_clr", 64'(gnt), 64'd0);
    check("to_no_done", 64'(n_pulse + int'(done != 2'b00)), 64'd0);
    f_on = 1'b0;
    req = 2'b01;
    wait_gnt("to_next");
    check("to_next_gnt", 64'(gnt), 64'h1);
    req = 2'b00;
    wait_done("to_next", d);
    check("to_next_done", 64'(d), 64'h1);
    check("to_err_sticky", 64'(err), 64'd1);
`else
    check("no_timeout_err", 64'(err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
